// File: rtl/ahb_mgr.sv
// ============================================================================
// Module   : ahb_mgr
// Brief    : AHB-Lite manager turning a command/data stream into pipelined
//            address/data phases. Define AHB_MGR_TIMEOUT_EN for hready timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ahb_mgr #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [63:0]       wd_data,
  output logic              rd_valid,
  output logic [63:0]       rd_data,
  output logic              done,
  output logic              done_err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic [2:0]        hburst,
  output logic              hwrite,
  output logic [63:0]       hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [63:0]       hrdata
);

  localparam logic [1:0] c_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] c_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] c_TRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_ERR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              r_state, w_state_nx;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [2:0]          r_burst;
  logic                r_write;
  logic [4:0]          r_cnt;       // address phases still to be issued
  logic                r_dp_valid;  // a data phase is outstanding
  logic [63:0]         r_wdata;
  logic                r_err;

  logic                w_accept, w_ap_go, w_err_set, w_tmo_hit;
  logic                w_burst_ok, w_misalign, w_cmd_bad;
  logic [4:0]          w_beats;
  logic [ADDR_W+7:0]   w_end;
  logic [ADDR_W-1:0]   w_step;

  // Command legality: burst code, size, alignment and end-of-space crossing
  always_comb begin
    w_burst_ok = 1'b1;
    w_beats    = 5'd1;
    case (cmd_burst)
      3'b000:  w_beats = 5'd1;
      3'b011:  w_beats = 5'd4;
      3'b101:  w_beats = 5'd8;
      3'b111:  w_beats = 5'd16;
      default: w_burst_ok = 1'b0;
    endcase
  end

  assign w_misalign = ((cmd_size == 2'b01) && cmd_addr[0]) ||
                      ((cmd_size == 2'b11) && (cmd_addr[2:0] != 3'd0));
  assign w_end      = {8'd0, cmd_addr}
                    + ({{(ADDR_W+3){1'b0}}, w_beats} << cmd_size)
                    - {{(ADDR_W+7){1'b0}}, 1'b1};
  assign w_cmd_bad  = !w_burst_ok || (cmd_size == 2'b10) || w_misalign ||
                      (|w_end[ADDR_W+7:ADDR_W]);
  assign w_step     = {{(ADDR_W-1){1'b0}}, 1'b1} << r_size;
  assign w_accept   = (r_state == S_IDLE) && cmd_valid;

`ifdef AHB_MGR_TIMEOUT_EN
  localparam int                 c_TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES);
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               w_tmo_pend;

  assign w_tmo_pend = ((r_state == S_DATA) && r_dp_valid) || (r_state == S_ERR);
  assign w_tmo_hit  = w_tmo_pend && (r_tmo_cnt == c_TMO_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_tmo_cnt <= '0;
    else if (!w_tmo_pend || hready)
      r_tmo_cnt <= '0;
    else if (!w_tmo_hit)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_ap_go    = 1'b0;
    w_err_set  = 1'b0;
    cmd_ready  = 1'b0;
    rd_valid   = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    hsel       = 1'b0;
    htrans     = c_TRANS_IDLE;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_state_nx = w_cmd_bad ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        hsel = 1'b1;
        if (!r_write || wd_valid) begin
          htrans = c_TRANS_NONSEQ;
          if (hready) begin
            w_ap_go    = 1'b1;
            w_state_nx = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (r_dp_valid && hresp) begin
          // First error cycle: cancel the burst right away
          w_err_set  = 1'b1;
          w_state_nx = hready ? S_DONE : S_ERR;
        end else begin
          if (r_cnt != 5'd0) begin
            hsel = 1'b1;
            if (!r_write || wd_valid) begin
              htrans  = c_TRANS_SEQ;
              w_ap_go = hready;
            end else begin
              htrans = c_TRANS_BUSY;
            end
          end else if (hready) begin
            w_state_nx = S_DONE;
          end
          rd_valid = r_dp_valid && hready && !r_write;
        end
      end
      S_ERR: begin
        w_err_set = 1'b1;
        if (hready) w_state_nx = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        done_err   = r_err;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_tmo_hit) begin
      hsel       = 1'b0;
      htrans     = c_TRANS_IDLE;
      w_ap_go    = 1'b0;
      rd_valid   = 1'b0;
      done       = 1'b1;
      done_err   = 1'b1;
      w_state_nx = S_IDLE;
    end
  end

  assign wd_ready = w_ap_go && r_write;
  assign rd_data  = rd_valid ? hrdata : 64'd0;
  assign haddr    = r_addr;
  assign hsize    = r_size;
  assign hburst   = r_burst;
  assign hwrite   = r_write;
  assign hwdata   = r_wdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_size     <= 2'b00;
      r_burst    <= 3'b000;
      r_write    <= 1'b0;
      r_cnt      <= 5'd0;
      r_dp_valid <= 1'b0;
      r_wdata    <= 64'd0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_addr     <= cmd_addr;
        r_size     <= cmd_size;
        r_burst    <= cmd_burst;
        r_write    <= cmd_write;
        r_cnt      <= w_beats;
        r_dp_valid <= 1'b0;
        r_err      <= w_cmd_bad;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_ap_go) begin
        r_cnt <= r_cnt - 5'd1;
        // Hold the last beat's address so haddr never wraps
        if (r_cnt > 5'd1) r_addr <= r_addr + w_step;
        if (r_write) r_wdata <= wd_data;
      end
      if ((r_state == S_ADDR || r_state == S_DATA) && hready)
        r_dp_valid <= w_ap_go;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_mgr.sv
// Directed bench for ahb_mgr: hand-computed bus sequences per cycle.
`default_nettype none

module tb_ahb_mgr;
  localparam int         ADDR_W = 10;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;

  logic              clk = 1'b0, n_rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_size;
  logic [2:0]        cmd_burst;
  logic              wd_valid, wd_ready;
  logic [63:0]       wd_data;
  logic              rd_valid;
  logic [63:0]       rd_data;
  logic              done, done_err;
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans, hsize;
  logic [2:0]        hburst;
  logic              hwrite;
  logic [63:0]       hwdata;
  logic              hready, hresp;
  logic [63:0]       hrdata;

  int n_checks = 0;
  int n_errs   = 0;

  ahb_mgr #(.TIMEOUT_CYCLES(64), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input string tag, input logic [1:0] t, input logic s, input logic [ADDR_W-1:0] a);
    check({tag, ".htrans"}, 64'(htrans), 64'(t));
    check({tag, ".hsel"}, 64'(hsel), 64'(s));
    if (s) check({tag, ".haddr"}, 64'(haddr), 64'(a));
  endtask

  task automatic rd(input string tag, input logic v, input logic [63:0] d);
    check({tag, ".rd_valid"}, 64'(rd_valid), 64'(v));
    if (v) check({tag, ".rd_data"}, rd_data, d);
  endtask

  // Offers a command for one cycle; returns at the start of the cycle after acceptance
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [1:0] sz, input logic [2:0] b);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_burst = b;
    #1;
    check("issue.cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic reject(input string tag, input logic [ADDR_W-1:0] a, input logic [1:0] sz, input logic [2:0] b);
    issue(1'b1, a, sz, b);
    #1;
    bus(tag, T_IDLE, 1'b0, '0);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".done_err"}, 64'(done_err), 64'd1);
    check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd0);
    tick();
    #1;
    check({tag, ".ready_after"}, 64'(cmd_ready), 64'd1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d[4];
    logic        v_wd[7];
    logic [1:0]  e_ht[7];
    logic [9:0]  e_ha[7];
    logic        e_hs[7];
    int          e_hwd[7];
    int          k, nrd;
    logic        got;

    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_size = 0; cmd_burst = 0;
    wd_valid = 0; wd_data = '0; hready = 1; hresp = 0; hrdata = '0;
    n_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    bus("rst", T_IDLE, 1'b0, '0);
    check("rst.cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst.done", 64'(done), 64'd0);
    check("rst.haddr", 64'(haddr), 64'd0);
    check("rst.hwdata", hwdata, 64'd0);
    check("rst.wd_ready", 64'(wd_ready), 64'd0);
    n_rst = 1;
    tick();

    // SINGLE write, no wait states
    wd_valid = 1; wd_data = 64'h1122334455667788;
    issue(1'b1, 10'h000, 2'b11, 3'b000);
    #1;
    bus("w1.c1", T_NS, 1'b1, 10'h000);
    check("w1.wd_ready", 64'(wd_ready), 64'd1);
    check("w1.hwrite", 64'(hwrite), 64'd1);
    tick();
    wd_valid = 0; #1;
    check("w1.hwdata", hwdata, 64'h1122334455667788);
    bus("w1.c2", T_IDLE, 1'b0, '0);
    check("w1.c2.done", 64'(done), 64'd0);
    tick(); #1;
    check("w1.done", 64'(done), 64'd1);
    check("w1.done_err", 64'(done_err), 64'd0);
    check("w1.cmd_ready", 64'(cmd_ready), 64'd0);
    tick(); #1;
    check("w1.ready_after", 64'(cmd_ready), 64'd1);
    tick();

    // INCR4 write with write data missing for two cycles before beat 3
    d     = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002, 64'hC2C2_0000_0000_0003, 64'hD3D3_0000_0000_0004};
    v_wd  = '{1, 1, 0, 0, 1, 1, 0};
    e_ht  = '{T_NS, T_SEQ, T_BUSY, T_BUSY, T_SEQ, T_SEQ, T_IDLE};
    e_ha  = '{10'h000, 10'h008, 10'h010, 10'h010, 10'h010, 10'h018, 10'h018};
    e_hs  = '{1, 1, 1, 1, 1, 1, 0};
    e_hwd = '{-1, 0, 1, -1, -1, 2, 3};
    k = 0;
    issue(1'b1, 10'h000, 2'b11, 3'b011);
    for (int c = 0; c < 7; c++) begin
      wd_valid = v_wd[c];
      wd_data  = (k < 4) ? d[k] : 64'd0;
      #1;
      bus($sformatf("w4.c%0d", c + 1), e_ht[c], e_hs[c], e_ha[c]);
      check($sformatf("w4.c%0d.wd_ready", c + 1), 64'(wd_ready),
            64'(v_wd[c] && (e_ht[c] == T_NS || e_ht[c] == T_SEQ)));
      if (e_hwd[c] >= 0) check($sformatf("w4.c%0d.hwdata", c + 1), hwdata, d[e_hwd[c]]);
      if (wd_ready) k++;
      tick();
    end
    wd_valid = 0; #1;
    check("w4.beats", 64'(k), 64'd4);
    check("w4.done", 64'(done), 64'd1);
    check("w4.done_err", 64'(done_err), 64'd0);
    tick();

    // SINGLE read with three wait states
    issue(1'b0, 10'h018, 2'b11, 3'b000);
    #1;
    bus("r1.c1", T_NS, 1'b1, 10'h018);
    check("r1.hwrite", 64'(hwrite), 64'd0);
    tick();
    hready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      rd($sformatf("r1.wait%0d", c), 1'b0, '0);
      bus($sformatf("r1.wait%0d", c), T_IDLE, 1'b0, '0);
      check($sformatf("r1.wait%0d.done", c), 64'(done), 64'd0);
      tick();
    end
    hready = 1; hrdata = 64'hDEADBEEFCAFEF00D; #1;
    rd("r1.data", 1'b1, 64'hDEADBEEFCAFEF00D);
    tick();
    hrdata = '0; #1;
    rd("r1.after", 1'b0, '0);
    check("r1.done", 64'(done), 64'd1);
    check("r1.done_err", 64'(done_err), 64'd0);
    tick();

    // INCR8 read, error response on the third beat
    issue(1'b0, 10'h000, 2'b11, 3'b101);
    #1; bus("e8.c1", T_NS, 1'b1, 10'h000); tick();
    hrdata = 64'h0101; #1; rd("e8.b0", 1'b1, 64'h0101); bus("e8.c2", T_SEQ, 1'b1, 10'h008); tick();
    hrdata = 64'h0202; #1; rd("e8.b1", 1'b1, 64'h0202); bus("e8.c3", T_SEQ, 1'b1, 10'h010); tick();
    hready = 0; hresp = 1; hrdata = 64'h0303; #1;
    rd("e8.err1", 1'b0, '0); bus("e8.err1", T_IDLE, 1'b0, '0); tick();
    hready = 1; #1;
    rd("e8.err2", 1'b0, '0); bus("e8.err2", T_IDLE, 1'b0, '0);
    check("e8.err2.done", 64'(done), 64'd0);
    tick();
    hresp = 0; hrdata = '0; #1;
    check("e8.done", 64'(done), 64'd1);
    check("e8.done_err", 64'(done_err), 64'd1);
    tick();

    // Rejected commands: no bus activity, error completion next cycle
    reject("rej.cross", 10'h3F8, 2'b11, 3'b011);
    reject("rej.align", 10'h021, 2'b01, 3'b000);
    reject("rej.burst", 10'h000, 2'b00, 3'b001);
    reject("rej.size",  10'h000, 2'b10, 3'b000);

    // Legal burst ending exactly at the top of the address space
    issue(1'b0, 10'h3E0, 2'b11, 3'b011);
    #1; bus("bnd.c1", T_NS, 1'b1, 10'h3E0);
    got = 0; nrd = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(); #1;
      if (rd_valid) nrd++;
      if (done) begin
        got = 1;
        check("bnd.done_err", 64'(done_err), 64'd0);
      end
    end
    check("bnd.done_seen", 64'(got), 64'd1);
    check("bnd.rd_count", 64'(nrd), 64'd4);
    tick();

    // Reset in the middle of an INCR16 read
    issue(1'b0, 10'h000, 2'b00, 3'b111);
    #1; bus("rst16.c1", T_NS, 1'b1, 10'h000); tick();
    #1; bus("rst16.c2", T_SEQ, 1'b1, 10'h001); tick();
    #1; bus("rst16.c3", T_SEQ, 1'b1, 10'h002);
    n_rst = 0; #1;
    bus("rst16.async", T_IDLE, 1'b0, '0);
    check("rst16.cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    n_rst = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rst16.nodone%0d", i), 64'(done), 64'd0);
      bus($sformatf("rst16.idle%0d", i), T_IDLE, 1'b0, '0);
      check($sformatf("rst16.ready%0d", i), 64'(cmd_ready), 64'd1);
      tick();
    end

`ifdef AHB_MGR_TIMEOUT_EN
    // Subordinate never completes the data phase
    issue(1'b0, 10'h040, 2'b11, 3'b000);
    #1; bus("tmo.c1", T_NS, 1'b1, 10'h040); tick();
    hready = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      check($sformatf("tmo.wait%0d", i), 64'(done), 64'd0);
      tick();
    end
    #1;
    check("tmo.done", 64'(done), 64'd1);
    check("tmo.done_err", 64'(done_err), 64'd1);
    bus("tmo.bus", T_IDLE, 1'b0, '0);
    tick();
    hready = 1; #1;
    check("tmo.ready_after", 64'(cmd_ready), 64'd1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
